seven_segment_scanner: RTL and testbench

Time-multiplexed display driver that sits directly downstream of the LED counter. It takes the `NUM` parallel 8-bit segment patterns the counter decodes and drives one shared segment bus plus a one-hot digit-select bus, as required by boards with common-segment multi-digit displays. Per digit slot it:
- inserts an anti-ghosting blank interval;
- applies 4-bit PWM brightness;
- snapshots all digit patterns once per frame, so a count change never tears a frame.

---
 rtl/seven_segment_pkg.sv | 23 ++
 rtl/scan_slot_timer.sv | 57 +++++
 rtl/seven_segment_scanner.sv | 143 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_pkg
// Description : Shared types and constants for the seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_pkg;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF  = 8'h00;
    localparam int         PWM_BITS = 4;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_slot_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_slot_timer
// Description : Slot timer t (0..DIGIT_CYCLES-1) and slot index s (0..NUM-1)
//               with end-of-slot and end-of-frame strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_slot_timer
    import seven_segment_pkg::*;
#(
    parameter int DIGIT_CYCLES = 20,
    parameter int NUM          = 6
) (
    input  logic                              clock_i,
    input  logic                              reset_n_i,
    output logic [width_of(DIGIT_CYCLES)-1:0] t_o,
    output logic [width_of(NUM)-1:0]          s_o,
    output logic                              slot_wrap_o,
    output logic                              frame_wrap_o
);

    localparam int TW = width_of(DIGIT_CYCLES);
    localparam int SW = width_of(NUM);
    localparam logic [TW-1:0] T_LAST = TW'(DIGIT_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(NUM - 1);

    logic [TW-1:0] t_q, t_d;
    logic [SW-1:0] s_q, s_d;

    assign slot_wrap_o  = (t_q == T_LAST);
    assign frame_wrap_o = slot_wrap_o && (s_q == S_LAST);
    assign t_o          = t_q;
    assign s_o          = s_q;

    // Next-state: t wraps every slot, s advances on each t wrap.
    always_comb begin
        t_d = t_q + 1'b1;
        s_d = s_q;
        if (slot_wrap_o) begin
            t_d = '0;
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
        end
    end

    // Timer registers.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            t_q <= '0;
            s_q <= '0;
        end else begin
            t_q <= t_d;
            s_q <= s_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed multi-digit display driver with anti-ghost
//               blanking, 4-bit PWM brightness and per-frame pattern latch.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM          = 6,
    parameter int CLOCK_HZ     = 50000000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BLANK_CYCLES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM-1:0][7:0]      seven_segment,
    input  logic [PWM_BITS-1:0]      brightness,
    output logic [7:0]               segments_out,
    output logic [NUM-1:0]           digit_select,
    output logic                     frame_start
);

    localparam int NUM_SAFE     = (NUM >= 1) ? NUM : 1;
    localparam int DIGIT_CYCLES = CLOCK_HZ / (REFRESH_HZ * NUM_SAFE);
    localparam int TW           = width_of(DIGIT_CYCLES);
    localparam int SW           = width_of(NUM);
    localparam logic [TW-1:0]       BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [PWM_BITS-1:0] PWM_FULL   = {PWM_BITS{1'b1}};
    localparam logic [7:0]          SEG_INV    = {8{1'(ACTIVE_LOW != 0)}};
    localparam logic [NUM-1:0]      SEL_INV    = {NUM{1'(ACTIVE_LOW != 0)}};

    generate
        if (NUM < 1 || DIGIT_CYCLES < BLANK_CYCLES + 16) begin : g_param_check
            $error("seven_segment_scanner: need NUM >= 1 and DIGIT_CYCLES >= BLANK_CYCLES + 16");
        end
    endgenerate

    logic [TW-1:0] t;
    logic [SW-1:0] s;
    logic          slot_wrap;
    logic          frame_wrap;

    scan_slot_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .NUM          (NUM)
    ) u_timer (
        .clock_i      (clock),
        .reset_n_i    (reset_n),
        .t_o          (t),
        .s_o          (s),
        .slot_wrap_o  (slot_wrap),
        .frame_wrap_o (frame_wrap)
    );

    scan_state_t             state_q, state_d;
    logic [PWM_BITS-1:0]     p_q, p_d;
    logic [NUM-1:0][7:0]     frame_q;
    logic [PWM_BITS-1:0]     bright_q;
    logic                    first_q;     // high when t==0 and s==0 (frame latch cycle)
    logic [7:0]              seg_q, seg_d;
    logic [NUM-1:0]          sel_q, sel_d;
    logic                    fs_q;

    // In the latch cycle the incoming values are used directly so the
    // first output cycle of a frame already shows the new snapshot.
    logic [NUM-1:0][7:0]     frame_w;
    logic [PWM_BITS-1:0]     bright_w;
    logic [7:0]              pattern_w;
    logic [NUM-1:0]          onehot_w;

    assign frame_w  = first_q ? seven_segment : frame_q;
    assign bright_w = first_q ? brightness    : bright_q;

    // Select the current slot's pattern and its one-hot digit enable.
    always_comb begin
        pattern_w = SEG_OFF;
        onehot_w  = '0;
        for (int i = 0; i < NUM; i++) begin
            if (s == SW'(i)) begin
                pattern_w   = frame_w[i];
                onehot_w[i] = 1'b1;
            end
        end
    end

    // Scan FSM next state, PWM counter and unpolarised output values.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        seg_d   = SEG_OFF;
        sel_d   = '0;
        case (state_q)
            SCAN_BLANK: if (BLANK_CYCLES == 0 || t == BLANK_LAST) state_d = SCAN_ON;
            SCAN_ON:    if (slot_wrap && BLANK_CYCLES != 0)       state_d = SCAN_BLANK;
            default:    state_d = SCAN_BLANK;
        endcase
        if (state_d == SCAN_ON && state_q != SCAN_ON) begin
            p_d = '0;
        end else if (state_q == SCAN_ON) begin
            p_d = p_q + 1'b1;
        end
        if (state_q == SCAN_ON) begin
            seg_d = pattern_w;
            if (bright_w == PWM_FULL || p_q < bright_w) begin
                sel_d = onehot_w;
            end
        end
    end

    // State, PWM, frame latch and polarised output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SCAN_BLANK;
            p_q      <= '0;
            frame_q  <= '0;
            bright_q <= '0;
            first_q  <= 1'b1;
            seg_q    <= SEG_OFF ^ SEG_INV;
            sel_q    <= SEL_INV;
            fs_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            first_q <= frame_wrap;
            if (first_q) begin
                frame_q  <= seven_segment;
                bright_q <= brightness;
            end
            seg_q <= seg_d ^ SEG_INV;
            sel_q <= sel_d ^ SEL_INV;
            fs_q  <= first_q;
        end
    end

    assign segments_out = seg_q;
    assign digit_select = sel_q;
    assign frame_start  = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scanner
// Description : Self-checking bench for seven_segment_scanner (NUM=6,
//               DIGIT_CYCLES=20, BLANK_CYCLES=2, active-low pins).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    localparam int NUM   = 6;
    localparam int DC    = 20;
    localparam int BL    = 2;
    localparam int FRAME = NUM * DC;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b1;
    logic [NUM-1:0][7:0] seven_segment;
    logic [3:0]          brightness;
    logic [7:0]          segments_out;
    logic [NUM-1:0]      digit_select;
    logic                frame_start;

    int          checks = 0;
    int          errors = 0;
    int unsigned tm     = 0;   // internal scan time consumed at the next edge
    int          sel_cycles = 0;
    logic [NUM-1:0][7:0] lat_pat;
    logic [3:0]          lat_b;

    seven_segment_scanner #(
        .NUM          (NUM),
        .CLOCK_HZ     (1200),
        .REFRESH_HZ   (10),
        .BLANK_CYCLES (BL),
        .ACTIVE_LOW   (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .seven_segment (seven_segment),
        .brightness    (brightness),
        .segments_out  (segments_out),
        .digit_select  (digit_select),
        .frame_start   (frame_start)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (time %0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: the reference derives slot, offset and PWM phase from the
    // elapsed scan time with plain arithmetic, then compares after the edge.
    task automatic cycle();
        int t, s, p;
        logic [5:0] one;
        logic [7:0] eseg;
        logic [5:0] esel;
        logic       efs;
        @(posedge clock);
        t   = int'(tm % DC);
        s   = int'((tm / DC) % NUM);
        efs = ((tm % FRAME) == 0);
        if (efs) begin
            lat_pat = seven_segment;
            lat_b   = brightness;
        end
        if (t < BL) begin
            eseg = 8'hFF;
            esel = 6'h3F;
        end else begin
            eseg = ~lat_pat[s];
            p    = (t - BL) % 16;
            one  = 6'd1 << s;
            esel = (lat_b == 4'd15 || p < int'(lat_b)) ? ~one : 6'h3F;
        end
        tm++;
        #1;
        check("segments", 32'(segments_out), 32'(eseg));
        check("digit_select", 32'(digit_select), 32'(esel));
        check("frame_start", 32'(frame_start), 32'(efs));
        check("onehot", 32'($countones(~digit_select) <= 1), 32'd1);
        if (digit_select != 6'h3F) sel_cycles++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Stop just before the edge that performs the next frame latch.
    task automatic run_to_frame();
        while ((tm % FRAME) != 0) cycle();
    endtask

    task automatic randomize_patterns(input logic [7:0] force_bits);
        for (int j = 0; j < NUM; j++) seven_segment[j] = 8'($urandom) | force_bits;
    endtask

    initial begin
        brightness = 4'd15;
        for (int j = 0; j < NUM; j++) seven_segment[j] = 8'h01 << j;

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("rst_seg", 32'(segments_out), 32'hFF);
        check("rst_sel", 32'(digit_select), 32'h3F);
        check("rst_fs", 32'(frame_start), 32'd0);
        @(posedge clock);
        #1;
        check("rst_hold_sel", 32'(digit_select), 32'h3F);
        @(negedge clock);
        reset_n = 1'b1;
        tm      = 0;

        // Walking-one patterns at full brightness for two frames.
        run(2 * FRAME);

        // Mid-frame change of digit 0 must not tear the current frame.
        run_to_frame();
        seven_segment[0] = 8'h3F;
        run(10);
        seven_segment[0] = 8'h06;
        run(FRAME - 10);
        run(FRAME);

        // Brightness 4: six selected cycles per slot, 36 per frame.
        run_to_frame();
        brightness = 4'd4;
        randomize_patterns(8'h00);
        sel_cycles = 0;
        run(FRAME);
        check("b4_frame_count", 32'(sel_cycles), 32'd36);

        // Brightness 0: no digit selected for a whole frame.
        run_to_frame();
        brightness = 4'd0;
        randomize_patterns(8'h00);
        sel_cycles = 0;
        run(FRAME);
        check("b0_frame_count", 32'(sel_cycles), 32'd0);

        // Random inputs changing at random points within frames.
        for (int k = 0; k < 6; k++) begin
            brightness = 4'($urandom_range(0, 15));
            randomize_patterns(8'h00);
            run(int'($urandom_range(30, 150)));
        end

        // Reset asserted at slot 3, t=10, with a lit digit on the bus.
        run_to_frame();
        brightness = 4'd15;
        randomize_patterns(8'h01);
        run(3 * DC + 10);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_seg", 32'(segments_out), 32'hFF);
        check("midrst_sel", 32'(digit_select), 32'h3F);
        check("midrst_fs", 32'(frame_start), 32'd0);
        @(posedge clock);
        #1;
        check("midrst_hold_seg", 32'(segments_out), 32'hFF);
        @(negedge clock);
        reset_n = 1'b1;
        tm      = 0;
        run(FRAME + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
